pref_issue_queue: RTL and testbench

//  Buffers the up-to-3 per-cycle prefetch candidates from the IP-stride prefetcher into a FIFO.

---
 rtl/pref_issue_queue_pkg.sv | 18 +
 rtl/pref_issue_queue_if.sv | 14 +
 rtl/pref_issue_queue_fifo.sv | 85 ++++++++
 rtl/pref_issue_queue.sv | 142 ++++++++++++++
 tb/tb_pref_issue_queue.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pref_issue_queue_pkg.sv
// Shared types for the prefetch issue queue: addresses, presented request, FSM states.
package pref_pkg;
  localparam int LOG2_BLOCK_SIZE = 6;

  typedef logic [63:0]                  addr_t;
  typedef logic [63-LOG2_BLOCK_SIZE:0]  cla_t;

  typedef struct packed {
    addr_t addr;
    logic  valid;
  } pref_req_t;

  typedef enum logic {IQ_IDLE, IQ_ISSUE} iq_state_e;

  function automatic addr_t blk_align(addr_t a, int lbs);
    return a & ~((64'd1 << lbs) - 64'd1);
  endfunction
endpackage

// File: rtl/pref_issue_queue_if.sv
// Candidate bus from the prefetcher and valid/ready request port toward the L2 arbiter.
interface pref_issue_queue_if;
  import pref_pkg::*;
  addr_t [2:0] cand_addr_i;
  logic  [2:0] cand_valid_i;
  logic        req_valid_o;
  addr_t       req_addr_o;
  logic        req_ready_i;

  modport master (input cand_addr_i, cand_valid_i, req_ready_i,
                  output req_valid_o, req_addr_o);
  modport slave  (output cand_addr_i, cand_valid_i, req_ready_i,
                  input req_valid_o, req_addr_o);
endinterface

// File: rtl/pref_issue_queue_fifo.sv
// pref_fifo_3w1r: circular FIFO, up to 3 compacted writes and 1 pop per cycle.
// Caller guarantees the number of writes never exceeds free_o.
module pref_fifo_3w1r
  import pref_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [2:0]            wr_en_i,
  input  addr_t [2:0]           wr_data_i,
  input  logic                  rd_en_i,
  output addr_t                 head_o,
  output addr_t                 head_nxt_o,
  output addr_t [DEPTH-1:0]     mem_o,
  output logic  [DEPTH-1:0]     ent_vld_o,
  output logic  [CW-1:0]        count_o,
  output logic  [CW-1:0]        free_o
);
  localparam int PW = $clog2(DEPTH);

  addr_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     widx, nxt_idx, off;
  logic [1:0]        nwr;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    nwr      = '0;
    widx     = '0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // accepted candidates pack into consecutive slots in index order
      for (int i = 0; i < 3; i++) begin
        if (wr_en_i[i]) begin
          widx        = wr_ptr_q + PW'(nwr);
          mem_d[widx] = wr_data_i[i];
          nwr         = nwr + 2'd1;
        end
      end
      wr_ptr_d = wr_ptr_q + PW'(nwr);
      rd_ptr_d = rd_ptr_q + PW'(rd_en_i);
      count_d  = count_q + CW'(nwr) - CW'(rd_en_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    nxt_idx   = rd_ptr_q + PW'(1);
    off       = '0;
    ent_vld_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      ent_vld_o[i] = {1'b0, off} < count_q;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign head_nxt_o = mem_q[nxt_idx];
  assign mem_o      = mem_q;
  assign count_o    = count_q;
  assign free_o     = CW'(DEPTH) - count_q;
endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: buffers up to 3 candidates/cycle, issues 1/cycle, yields to demand.
// Optional block-address dedup is enabled with PREF_DEDUP_EN.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int QUEUE_DEPTH     = 8,
  parameter int LOG2_BLOCK_SIZE = pref_pkg::LOG2_BLOCK_SIZE,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  pref_issue_queue_if.master  bus,
  input  logic                demand_busy_i,
  input  logic                flush_i,
  output logic [CNT_W-1:0]    drop_cnt_o,
  output logic [CNT_W-1:0]    issue_cnt_o
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  iq_state_e               state_q, state_d;
  pref_req_t               req_q, req_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d, issue_cnt_q, issue_cnt_d;
  logic [CNT_W:0]          drop_sum;
  addr_t                   head, head_nxt, first_wr;
  addr_t [QUEUE_DEPTH-1:0] mem;
  logic  [QUEUE_DEPTH-1:0] ent_vld;
  logic  [CW-1:0]          count, free, slots;
  logic  [2:0]             keep, wr_en;
  logic  [1:0]             nvld, nwr;
  logic                    accept;

`ifdef PREF_DEDUP_EN
  function automatic logic same_blk(addr_t a, addr_t b);
    return (a >> LOG2_BLOCK_SIZE) == (b >> LOG2_BLOCK_SIZE);
  endfunction
`else
  logic unused_dedup;
  assign unused_dedup = ^{mem, ent_vld};
`endif

  assign accept = req_q.valid & bus.req_ready_i;

  // dedup first, then hand out the free slots (sampled pre-pop) in index order
  always_comb begin
    keep = bus.cand_valid_i;
`ifdef PREF_DEDUP_EN
    for (int i = 0; i < 3; i++) begin
      if (req_q.valid && same_blk(bus.cand_addr_i[i], req_q.addr)) keep[i] = 1'b0;
      for (int e = 0; e < QUEUE_DEPTH; e++)
        if (ent_vld[e] && same_blk(bus.cand_addr_i[i], mem[e])) keep[i] = 1'b0;
      for (int j = 0; j < 3; j++)
        if (j < i && bus.cand_valid_i[j] && same_blk(bus.cand_addr_i[i], bus.cand_addr_i[j]))
          keep[i] = 1'b0;
    end
`endif
    wr_en    = '0;
    slots    = free;
    nvld     = '0;
    nwr      = '0;
    first_wr = '0;
    for (int i = 2; i >= 0; i--) begin
      if (bus.cand_valid_i[i]) nvld = nvld + 2'd1;
    end
    for (int i = 0; i < 3; i++) begin
      if (keep[i] && slots != '0 && !flush_i) begin
        wr_en[i] = 1'b1;
        slots    = slots - CW'(1);
        if (nwr == 2'd0) first_wr = bus.cand_addr_i[i];
        nwr      = nwr + 2'd1;
      end
    end
  end

  pref_fifo_3w1r #(.DEPTH(QUEUE_DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .wr_en_i    (wr_en),
    .wr_data_i  (bus.cand_addr_i),
    .rd_en_i    (accept),
    .head_o     (head),
    .head_nxt_o (head_nxt),
    .mem_o      (mem),
    .ent_vld_o  (ent_vld),
    .count_o    (count),
    .free_o     (free)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    issue_cnt_d = issue_cnt_q;
    drop_sum    = {1'b0, drop_cnt_q} + (CNT_W+1)'(nvld - nwr);
    drop_cnt_d  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    if (accept && issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + CNT_W'(1);
    unique case (state_q)
      IQ_IDLE: begin
        // an empty queue forwards this cycle's first accepted candidate
        if (!demand_busy_i && (count != '0 || nwr != 2'd0)) begin
          req_d.addr  = blk_align((count != '0) ? head : first_wr, LOG2_BLOCK_SIZE);
          req_d.valid = 1'b1;
          state_d     = IQ_ISSUE;
        end
      end
      IQ_ISSUE: begin
        if (accept) begin
          if (count > CW'(1) && !demand_busy_i) begin
            req_d.addr = blk_align(head_nxt, LOG2_BLOCK_SIZE);
          end else begin
            req_d.valid = 1'b0;
            state_d     = IQ_IDLE;
          end
        end
      end
      default: state_d = IQ_IDLE;
    endcase
    if (flush_i) begin
      state_d     = IQ_IDLE;
      req_d.valid = 1'b0;
      drop_cnt_d  = drop_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IQ_IDLE;
      req_q       <= '0;
      drop_cnt_q  <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      drop_cnt_q  <= drop_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.req_valid_o = req_q.valid;
  assign bus.req_addr_o  = req_q.addr;
  assign drop_cnt_o      = drop_cnt_q;
  assign issue_cnt_o     = issue_cnt_q;
endmodule

// File: tb/tb_pref_issue_queue.sv
// Scoreboard bench for pref_issue_queue: expected issue addresses queued at drive time,
// popped by a monitor on each observed handshake.
module tb_pref_issue_queue;
  import pref_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic demand_busy_i = 1'b0;
  logic flush_i = 1'b0;
  logic [15:0] drop_cnt_o, issue_cnt_o;
  int n_cmp = 0, n_err = 0;
  addr_t sbq[$];
  int exp_drop = 0, exp_issue = 0;

  always #5 clk = ~clk;

  pref_issue_queue_if bus();

  pref_issue_queue #(.QUEUE_DEPTH(8), .LOG2_BLOCK_SIZE(6), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .demand_busy_i (demand_busy_i),
    .flush_i       (flush_i),
    .drop_cnt_o    (drop_cnt_o),
    .issue_cnt_o   (issue_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cand(input logic [2:0] v, input addr_t a0, input addr_t a1, input addr_t a2);
    bus.cand_valid_i = v;
    bus.cand_addr_i[0] = a0;
    bus.cand_addr_i[1] = a1;
    bus.cand_addr_i[2] = a2;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int c = 0;
    while (sbq.size() != 0 && c < max_cyc) begin
      tick();
      c++;
    end
    chk({tag, "_drain_left"}, 64'(sbq.size()), 64'd0);
    tick();
    @(negedge clk);
    chk({tag, "_idle"}, {63'd0, bus.req_valid_o}, 64'd0);
    chk({tag, "_issue_cnt"}, {48'd0, issue_cnt_o}, 64'(exp_issue));
    chk({tag, "_drop_cnt"}, {48'd0, drop_cnt_o}, 64'(exp_drop));
  endtask

  // one handshake observed per cycle -> compare against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.req_valid_o && bus.req_ready_i) begin
      if (sbq.size() == 0) chk("unexp_issue", {63'd0, bus.req_valid_o}, 64'd0);
      else chk("issue_addr", bus.req_addr_o, sbq.pop_front());
    end
  end

  initial begin
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    bus.req_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, bus.req_valid_o}, 64'd0);
    chk("rst_addr", bus.req_addr_o, 64'd0);
    chk("rst_cnts", {32'd0, drop_cnt_o, issue_cnt_o}, 64'd0);
    rst = 1'b0;
    tick();

    // T1: idle with nothing queued
    bus.req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", {63'd0, bus.req_valid_o}, 64'd0);
      chk("t1_cnts", {32'd0, drop_cnt_o, issue_cnt_o}, 64'd0);
      tick();
    end

    // T2: three candidates issue on consecutive cycles
    set_cand(3'b111, 64'h1040, 64'h1080, 64'h10C0);
    sbq.push_back(64'h1040); sbq.push_back(64'h1080); sbq.push_back(64'h10C0);
    tick();
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    chk("t2_latency", {63'd0, bus.req_valid_o}, 64'd1);
    exp_issue += 3;
    drain("t2", 10);

    // T3: fill with ready low, overflow, then full+pop+3
    bus.req_ready_i = 1'b0;
    set_cand(3'b111, 64'h3000, 64'h3040, 64'h3080); tick();
    set_cand(3'b111, 64'h30C0, 64'h3100, 64'h3140); tick();
    set_cand(3'b011, 64'h3180, 64'h31C0, 64'h0);    tick();
    for (int i = 0; i < 8; i++) sbq.push_back(64'h3000 + 64'(i) * 64'h40);
    set_cand(3'b111, 64'h4000, 64'h4040, 64'h4080); tick();
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    exp_drop += 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_addr", bus.req_addr_o, 64'h3000);
      chk("t3_hold_valid", {63'd0, bus.req_valid_o}, 64'd1);
      tick();
    end
    chk("t3_drop", {48'd0, drop_cnt_o}, 64'(exp_drop));
    bus.req_ready_i = 1'b1;
    set_cand(3'b111, 64'h5000, 64'h5040, 64'h5080); tick();
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    exp_drop += 3;
    exp_issue += 8;
    drain("t3", 20);

    // T4: demand busy lets the presented request go but blocks the next
    set_cand(3'b011, 64'h6000, 64'h6040, 64'h0);
    sbq.push_back(64'h6000); sbq.push_back(64'h6040);
    tick();
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    demand_busy_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_blocked", {63'd0, bus.req_valid_o}, 64'd0);
      tick();
    end
    chk("t4_pending", 64'(sbq.size()), 64'd1);
    demand_busy_i = 1'b0;
    exp_issue += 2;
    drain("t4", 10);

    // T5: flush five queued entries while candidates arrive
    bus.req_ready_i = 1'b0;
    set_cand(3'b111, 64'h7000, 64'h7040, 64'h7080); tick();
    set_cand(3'b011, 64'h70C0, 64'h7100, 64'h0);    tick();
    flush_i = 1'b1;
    set_cand(3'b111, 64'h7200, 64'h7240, 64'h7280); tick();
    flush_i = 1'b0;
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    bus.req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_flushed", {63'd0, bus.req_valid_o}, 64'd0);
      tick();
    end
    chk("t5_drop", {48'd0, drop_cnt_o}, 64'(exp_drop));
    chk("t5_issue", {48'd0, issue_cnt_o}, 64'(exp_issue));
    set_cand(3'b001, 64'h8000, 64'h0, 64'h0);
    sbq.push_back(64'h8000);
    tick();
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    exp_issue += 1;
    drain("t5", 10);

    // T6: duplicates against queue/presented request and within the cycle
    bus.req_ready_i = 1'b0;
    set_cand(3'b001, 64'h2000, 64'h0, 64'h0); tick();
    set_cand(3'b111, 64'h2000, 64'h2010, 64'h2040); tick();
    set_cand(3'b000, 64'd0, 64'd0, 64'd0);
    sbq.push_back(64'h2000);
`ifdef PREF_DEDUP_EN
    sbq.push_back(64'h2040);
    exp_drop += 2;
    exp_issue += 2;
`else
    sbq.push_back(64'h2000); sbq.push_back(64'h2000); sbq.push_back(64'h2040);
    exp_issue += 4;
`endif
    @(negedge clk);
    chk("t6_drop", {48'd0, drop_cnt_o}, 64'(exp_drop));
    tick();
    bus.req_ready_i = 1'b1;
    drain("t6", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
